vliw_core: RTL and testbench
============================

// Module: vliw_core
// PURPOSE
//  Two-slot 64-bit VLIW processor core. Fetches 64-bit instruction bundles over a single shared memory bus
//  to a synchronous RAM with one-cycle read latency. Executes both slots in parallel against a 16x64 register file.
//  Top-level CPU of the SoC; the RAM and the bench attach directly to its bus ports.
// PARAMETERS
//  RESET_PC   56'h0   fetch address after reset
//  NREGS      16      architectural registers; r0 reads 0, writes to it are discarded
// PORTS
//  clk          in   1   single clock; all state changes on posedge
//  rst          in   1   reset; asynchronous, active-high
//  addressBus   out  56  byte address to RAM; bits [2:0] ignored (8-byte words)
//  dataIn       in   64  read data from RAM; valid the cycle after RAM samples addressBus
//  dataOut      out  64  store data to RAM
//  enableWrite  out  1   RAM write strobe; RAM commits dataOut at the posedge it samples this high
// BEHAVIOUR
//  Reset (async, rst=1):
//   - pc=RESET_PC, state=FETCH, all regs=0.
//   - addressBus=0, dataOut=0, enableWrite=0.
//   - An in-flight store is aborted immediately (enableWrite drops asynchronously).
//  Bundle layout: slot0=bits[31:0] (ALU only), slot1=bits[63:32] (ALU, memory, control).
//  Op fields: [31:26] op, [25:22] rd, [21:18] rs1, [17:14] rs2, [13:0] imm (sign-extended to 64).
//  Opcodes:
//   - 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 XOR
//   - 6 SHL rs1<<rs2[5:0]; 7 SHR (logical); 8 ADDI rd=rs1+imm; 9 LDI rd=imm
//   - slot1 only: 16 LD rd=mem[rs1+imm]; 17 ST mem[rs1+imm]=rs2; 18 BEQ if rs1==rs2 pc+=imm*8; 19 JMP pc+=imm*8; 63 HALT
//   - Undefined opcode, or a slot1-only op in slot0: executes as NOP.
//  Arithmetic: 64-bit, wraps modulo 2^64, no flags; pc wraps modulo 2^56.
//  Parallel semantics: both slots read register values from before the bundle.
//   - Same rd in both slots: slot1 result wins.
//   - A load's rd write lands in WB, after slot0's write.
//  FSM (one state per cycle):
//   - FETCH: addressBus<=pc, enableWrite=0 -> FWAIT.
//   - FWAIT: RAM reads -> EXEC.
//   - EXEC: bundle=dataIn; ALU writes occur.
//     LD/ST -> MEM; HALT -> HALT; else pc<=next -> FETCH.
//     next = branch/jump target (taken) or pc+8.
//   - MEM: addressBus<=rs1+imm; ST also drives dataOut=rs2 and enableWrite=1.
//     ST -> FETCH (pc+8, enableWrite back to 0); LD -> MWAIT.
//   - MWAIT -> WB: rd<=dataIn, pc<=pc+8 -> FETCH.
//   - HALT: terminal; outputs hold, enableWrite=0; only rst exits.
//  Latency: ALU/branch bundle 3 cycles; ST 4 cycles; LD 5 cycles.
//  enableWrite is high exactly one cycle per ST and never during fetch.
// TESTING
//  - Hold rst=1 with clk toggling -> addressBus=0, enableWrite=0; after release, first fetch at addr 0.
//  - Bundle {ADDI r2=r0+7, LDI r1=5} then {ADD r3=r1+r2, NOP} -> r3=12; each bundle takes 3 cycles.
//  - Both slots write r4 (slot0 LDI 1, slot1 LDI 2) -> r4=2; write to r0 -> r0 stays 0.
//  - ST r1=0xDEAD to addr 0x100, then LD r5 from 0x100
//    -> one-cycle enableWrite pulse with addressBus=0x100; r5=0xDEAD.
//  - BEQ r0,r0,imm=-1 at pc 0x18 -> next fetch at 0x10.
//    BEQ with unequal operands -> fetch 0x20.
//  - HALT -> bus frozen, enableWrite=0 for 50 cycles; assert rst mid-store -> enableWrite drops at once, pc=0.

Source files
------------

// File: rtl/vliw_core.sv
// Two-slot 64-bit VLIW core: slot0 is ALU-only, slot1 adds load/store/branch/halt.
// Instruction and data traffic share one bus to a one-cycle-latency synchronous RAM.
module vliw_core #(
  parameter logic [55:0] RESET_PC = 56'h0,
  parameter int unsigned NREGS    = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic [55:0] addressBus,
  input  logic [63:0] dataIn,
  output logic [63:0] dataOut,
  output logic        enableWrite
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_FWAIT = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_MWAIT = 3'd4,
    S_HALT  = 3'd5
  } state_e;

  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_AND  = 6'd3;
  localparam logic [5:0] OP_OR   = 6'd4;
  localparam logic [5:0] OP_XOR  = 6'd5;
  localparam logic [5:0] OP_SHL  = 6'd6;
  localparam logic [5:0] OP_SHR  = 6'd7;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_LDI  = 6'd9;
  localparam logic [5:0] OP_LD   = 6'd16;
  localparam logic [5:0] OP_ST   = 6'd17;
  localparam logic [5:0] OP_BEQ  = 6'd18;
  localparam logic [5:0] OP_JMP  = 6'd19;
  localparam logic [5:0] OP_HALT = 6'd63;

  state_e      state_q;
  logic [55:0] pc_q;
  logic [63:0] regs_q [NREGS];
  logic [3:0]  ld_rd_q;
  logic        is_st_q;

  logic [5:0]  op0_s, op1_s;
  logic [3:0]  rd0_s, rd1_s;
  logic [63:0] a0_s, b0_s, imm0_s, a1_s, b1_s, imm1_s;
  logic [63:0] res0_s, res1_s;
  logic        we0_s, we1_s;
  logic [55:0] ea_s, pc_d;

  // Bit 64 flags a register write; anything that is not an ALU op writes nothing.
  function automatic logic [64:0] alu_f(input logic [5:0] op, input logic [63:0] a,
                                        input logic [63:0] b, input logic [63:0] imm);
    logic [64:0] r;
    case (op)
      OP_ADD:  r = {1'b1, a + b};
      OP_SUB:  r = {1'b1, a - b};
      OP_AND:  r = {1'b1, a & b};
      OP_OR:   r = {1'b1, a | b};
      OP_XOR:  r = {1'b1, a ^ b};
      OP_SHL:  r = {1'b1, a << b[5:0]};
      OP_SHR:  r = {1'b1, a >> b[5:0]};
      OP_ADDI: r = {1'b1, a + imm};
      OP_LDI:  r = {1'b1, imm};
      default: r = {1'b0, 64'd0};
    endcase
    return r;
  endfunction

  // Decode both slots from the bundle on dataIn against pre-bundle register values.
  always_comb begin
    op0_s  = dataIn[31:26];
    rd0_s  = dataIn[25:22];
    a0_s   = (dataIn[21:18] == 4'd0) ? 64'd0 : regs_q[dataIn[21:18]];
    b0_s   = (dataIn[17:14] == 4'd0) ? 64'd0 : regs_q[dataIn[17:14]];
    imm0_s = {{50{dataIn[13]}}, dataIn[13:0]};
    op1_s  = dataIn[63:58];
    rd1_s  = dataIn[57:54];
    a1_s   = (dataIn[53:50] == 4'd0) ? 64'd0 : regs_q[dataIn[53:50]];
    b1_s   = (dataIn[49:46] == 4'd0) ? 64'd0 : regs_q[dataIn[49:46]];
    imm1_s = {{50{dataIn[45]}}, dataIn[45:32]};
    {we0_s, res0_s} = alu_f(op0_s, a0_s, b0_s, imm0_s);
    {we1_s, res1_s} = alu_f(op1_s, a1_s, b1_s, imm1_s);
    ea_s = a1_s[55:0] + imm1_s[55:0];
    if ((op1_s == OP_JMP) || ((op1_s == OP_BEQ) && (a1_s == b1_s))) begin
      pc_d = pc_q + {imm1_s[52:0], 3'b000};
    end else begin
      pc_d = pc_q + 56'd8;
    end
  end

  // Bundle sequencer, register file and registered bus outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      ld_rd_q     <= 4'd0;
      is_st_q     <= 1'b0;
      addressBus  <= 56'd0;
      dataOut     <= 64'd0;
      enableWrite <= 1'b0;
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= 64'd0;
    end else begin
      case (state_q)
        S_FETCH: begin
          addressBus  <= pc_q;
          enableWrite <= 1'b0;
          state_q     <= S_FWAIT;
        end
        S_FWAIT: state_q <= S_EXEC;
        S_EXEC: begin
          // slot1 is written second so it wins a shared rd
          if (we0_s && (rd0_s != 4'd0)) regs_q[rd0_s] <= res0_s;
          if (we1_s && (rd1_s != 4'd0)) regs_q[rd1_s] <= res1_s;
          case (op1_s)
            OP_LD: begin
              addressBus <= ea_s;
              ld_rd_q    <= rd1_s;
              is_st_q    <= 1'b0;
              state_q    <= S_MEM;
            end
            OP_ST: begin
              addressBus  <= ea_s;
              dataOut     <= b1_s;
              enableWrite <= 1'b1;
              is_st_q     <= 1'b1;
              state_q     <= S_MEM;
            end
            OP_HALT: state_q <= S_HALT;
            default: begin
              pc_q    <= pc_d;
              state_q <= S_FETCH;
            end
          endcase
        end
        S_MEM: begin
          enableWrite <= 1'b0;
          if (is_st_q) begin
            pc_q    <= pc_q + 56'd8;
            state_q <= S_FETCH;
          end else begin
            state_q <= S_MWAIT;
          end
        end
        S_MWAIT: begin
          if (ld_rd_q != 4'd0) regs_q[ld_rd_q] <= dataIn;
          pc_q    <= pc_q + 56'd8;
          state_q <= S_FETCH;
        end
        S_HALT: enableWrite <= 1'b0;
        default: state_q <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_vliw_core.sv
// Lockstep bench for vliw_core: an instruction-level model predicts every fetch address,
// store/load bus cycle and halt, against a bench-side synchronous RAM.
module tb_vliw_core;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [55:0] addressBus;
  logic [63:0] dataIn;
  logic [63:0] dataOut;
  logic        enableWrite;

  always #5 clk = ~clk;

  vliw_core dut (
    .clk(clk), .rst(rst), .addressBus(addressBus), .dataIn(dataIn),
    .dataOut(dataOut), .enableWrite(enableWrite)
  );

  logic [63:0] ram [0:511];
  logic        ld_en = 1'b0;
  logic        clr = 1'b0;
  logic [8:0]  ld_addr = 9'd0;
  logic [63:0] ld_data = 64'd0;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 512; i++) ram[i] <= 64'd0;
    end else if (ld_en) begin
      ram[ld_addr] <= ld_data;
    end else if (enableWrite) begin
      ram[addressBus[11:3]] <= dataOut;
    end
    dataIn <= ram[addressBus[11:3]];
  end

  logic [63:0] mm [0:511];
  logic [63:0] rm [0:15];
  logic [55:0] pcm;
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] enc(input int op, input int rd, input int rs1,
                                      input int rs2, input int imm);
    logic [31:0] w;
    w = {op[5:0], rd[3:0], rs1[3:0], rs2[3:0], imm[13:0]};
    return w;
  endfunction

  function automatic logic [63:0] m_alu(input int op, input logic [63:0] a,
                                        input logic [63:0] b, input logic [63:0] imm);
    case (op)
      1: return a + b;
      2: return a - b;
      3: return a & b;
      4: return a | b;
      5: return a ^ b;
      6: return a << b[5:0];
      7: return a >> b[5:0];
      8: return a + imm;
      9: return imm;
      default: return 64'd0;
    endcase
  endfunction

  task automatic put(input int idx, input logic [63:0] w);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = idx[8:0]; ld_data = w;
    @(negedge clk);
    ld_en = 1'b0;
    mm[idx] = w;
  endtask

  task automatic clear_mem();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    for (int i = 0; i < 512; i++) mm[i] = 64'd0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) rm[i] = 64'd0;
    pcm = 56'd0;
  endtask

  // One bundle at ISA level: returns its cycle count and any store it performs.
  task automatic model_step(output int lat, output bit st, output bit halt,
                            output logic [55:0] ea, output logic [63:0] sd);
    logic [63:0] w, a0, b0, a1, b1, i0, i1, t64;
    logic [63:0] old [0:15];
    logic signed [13:0] s;
    int op0, op1, rd0, rd1;
    w = mm[pcm[11:3]];
    for (int i = 0; i < 16; i++) old[i] = rm[i];
    op0 = int'(w[31:26]); rd0 = int'(w[25:22]);
    a0 = old[w[21:18]]; b0 = old[w[17:14]];
    s = w[13:0]; i0 = longint'(s);
    op1 = int'(w[63:58]); rd1 = int'(w[57:54]);
    a1 = old[w[53:50]]; b1 = old[w[49:46]];
    s = w[45:32]; i1 = longint'(s);
    lat = 3; st = 0; halt = 0; ea = 56'd0; sd = 64'd0;
    if (op0 >= 1 && op0 <= 9 && rd0 != 0) rm[rd0] = m_alu(op0, a0, b0, i0);
    if (op1 >= 1 && op1 <= 9 && rd1 != 0) rm[rd1] = m_alu(op1, a1, b1, i1);
    t64 = a1 + i1;
    t64 = t64 % (64'd1 << 56);
    ea = t64[55:0];
    t64 = pcm + 64'd8;
    case (op1)
      16: begin lat = 5; if (rd1 != 0) rm[rd1] = mm[ea[11:3]]; end
      17: begin lat = 4; st = 1; sd = b1; mm[ea[11:3]] = b1; end
      18: if (a1 == b1) t64 = pcm + i1 * 64'd8;
      19: t64 = pcm + i1 * 64'd8;
      63: halt = 1;
      default: ;
    endcase
    if (!halt) pcm = t64[55:0];
  endtask

  // Called at the negedge right after a fetch edge; follows the program to HALT.
  task automatic run_prog(input string nm, input int max_b);
    int lat; bit st, halt, done;
    logic [55:0] ea, p;
    logic [63:0] sd;
    done = 0;
    for (int b = 0; b < max_b && !done; b++) begin
      p = pcm;
      chk({nm, " fetch addr"}, {8'd0, addressBus}, {8'd0, p});
      chk({nm, " fetch we"}, {63'd0, enableWrite}, 64'd0);
      model_step(lat, st, halt, ea, sd);
      if (halt) begin
        for (int c = 0; c < 50; c++) begin
          @(negedge clk);
          chk({nm, " halt addr"}, {8'd0, addressBus}, {8'd0, p});
          chk({nm, " halt we"}, {63'd0, enableWrite}, 64'd0);
        end
        done = 1;
      end else begin
        for (int c = 1; c < lat; c++) begin
          @(negedge clk);
          if (c == 2 && lat > 3) begin
            chk({nm, " mem addr"}, {8'd0, addressBus}, {8'd0, ea});
            chk({nm, " mem we"}, {63'd0, enableWrite}, {63'd0, st});
            if (st) chk({nm, " st data"}, dataOut, sd);
          end else begin
            chk({nm, " idle we"}, {63'd0, enableWrite}, 64'd0);
          end
        end
        @(negedge clk);
      end
    end
    chk({nm, " halt reached"}, {63'd0, done}, 64'd1);
  endtask

  task automatic start();
    model_reset();
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int r, k, ops0 [15];
    logic [31:0] s0w, s1w;
    ops0 = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 16, 17, 19, 63, 42};
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset addr", {8'd0, addressBus}, 64'd0);
    chk("reset we", {63'd0, enableWrite}, 64'd0);
    chk("reset dout", dataOut, 64'd0);

    // ALU, dual-write, r0, store/load
    clear_mem();
    put(0,  {enc(9, 1, 0, 0, 5),   enc(8, 2, 0, 0, 7)});
    put(1,  {enc(0, 0, 0, 0, 0),   enc(1, 3, 1, 2, 0)});
    put(2,  {enc(9, 4, 0, 0, 2),   enc(9, 4, 0, 0, 1)});
    put(3,  {enc(17, 0, 0, 3, 288), enc(9, 0, 0, 0, 9)});
    put(4,  {enc(17, 0, 0, 4, 264), enc(0, 0, 0, 0, 0)});
    put(5,  {enc(17, 0, 0, 0, 272), enc(0, 0, 0, 0, 0)});
    put(6,  {enc(9, 1, 0, 0, 222), enc(9, 7, 0, 0, 8)});
    put(7,  {enc(0, 0, 0, 0, 0),   enc(6, 1, 1, 7, 0)});
    put(8,  {enc(0, 0, 0, 0, 0),   enc(8, 1, 1, 0, 173)});
    put(9,  {enc(17, 0, 0, 1, 256), enc(0, 0, 0, 0, 0)});
    put(10, {enc(16, 5, 0, 0, 256), enc(9, 5, 0, 0, 1)});
    put(11, {enc(17, 0, 0, 5, 280), enc(0, 0, 0, 0, 0)});
    put(12, {enc(63, 0, 0, 0, 0),  enc(0, 0, 0, 0, 0)});
    start();
    run_prog("p1", 40);
    chk("p1 r3 sum", ram[36], 64'd12);
    chk("p1 r4 slot1 wins", ram[33], 64'd2);
    chk("p1 r0 zero", ram[34], 64'd0);
    chk("p1 st dead", ram[32], 64'hDEAD);
    chk("p1 ld dead", ram[35], 64'hDEAD);

    // branches: fetch order 0,8,0x18,0x20,0x18,0x10
    rst = 1'b1;
    clear_mem();
    put(0, {enc(9, 6, 0, 0, 3),   32'd0});
    put(1, {enc(19, 0, 0, 0, 2),  32'd0});
    put(2, {enc(63, 0, 0, 0, 0),  32'd0});
    put(3, {enc(18, 0, 5, 6, -1), 32'd0});
    put(4, {enc(19, 0, 0, 0, -1), enc(9, 5, 0, 0, 3)});
    start();
    run_prog("br", 20);

    // reset in the middle of a store cycle
    rst = 1'b1;
    clear_mem();
    put(0, {enc(9, 3, 0, 0, 85),   32'd0});
    put(1, {enc(17, 0, 0, 3, 256), 32'd0});
    start();
    chk("ms fetch0", {8'd0, addressBus}, 64'd0);
    repeat (3) @(negedge clk);
    chk("ms fetch1", {8'd0, addressBus}, 64'd8);
    repeat (2) @(negedge clk);
    chk("ms st we", {63'd0, enableWrite}, 64'd1);
    chk("ms st addr", {8'd0, addressBus}, 64'h100);
    chk("ms st data", dataOut, 64'h55);
    #2 rst = 1'b1;
    #1;
    chk("ms abort we", {63'd0, enableWrite}, 64'd0);
    chk("ms abort addr", {8'd0, addressBus}, 64'd0);
    chk("ms abort dout", dataOut, 64'd0);
    repeat (2) @(negedge clk);
    put(0, {enc(16, 2, 0, 0, 256), 32'd0});
    put(1, {enc(17, 0, 0, 2, 264), enc(8, 3, 2, 0, 1)});
    put(2, {enc(17, 0, 0, 3, 272), 32'd0});
    put(3, {enc(63, 0, 0, 0, 0),   32'd0});
    start();
    run_prog("abort", 10);
    chk("abort no write", ram[32], 64'd0);

    // randomized programs
    for (int t = 0; t < 3; t++) begin
      rst = 1'b1;
      clear_mem();
      for (int i = 0; i < 40; i++) begin
        s0w = enc(ops0[$urandom_range(0, 14)], $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 15), $urandom_range(0, 16383));
        r = $urandom_range(0, 9);
        k = 2048 + 8 * $urandom_range(0, 255);
        if (r <= 5)
          s1w = enc((r == 5) ? 50 : $urandom_range(0, 9), $urandom_range(0, 15),
                    $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 16383));
        else if (r <= 7) s1w = enc(17, 0, 0, $urandom_range(0, 15), k);
        else if (r == 8) s1w = enc(16, $urandom_range(0, 15), 0, 0, k);
        else s1w = 32'd0;
        put(i, {s1w, s0w});
      end
      for (int j = 1; j < 16; j++) put(39 + j, {enc(17, 0, 0, j, 2048 + 8 * j), 32'd0});
      put(55, {enc(63, 0, 0, 0, 0), 32'd0});
      start();
      run_prog("rnd", 80);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
